mu0_control: RTL
================

// Module: mu0_control
// PURPOSE
//  Fetch/execute control FSM for the MU0 16-bit processor. Drives the select of the
//  12-bit address mux (0 = PC, 1 = IR[11:0]), the datapath register enables, the ALU
//  function and the memory strobes. Holds off on a memory ready handshake and parks
//  in HALT on STP. Sits directly upstream of the address mux and datapath registers.
// PARAMETERS
//  none (MU0 encoding fixed: 4-bit opcode, 12-bit address, 16-bit word)
// PORTS
//  clk        in   1  system clock, all state changes on rising edge
//  rst_n      in   1  asynchronous active-low reset
//  opcode     in   4  IR[15:12] from instruction register
//  flag_n     in   1  accumulator negative flag (Acc[15])
//  flag_z     in   1  accumulator zero flag (Acc == 0)
//  mem_ready  in   1  memory completes current access this cycle
//  addr_sel   out  1  address mux select: 0 = PC, 1 = IR[11:0]
//  x_sel      out  1  ALU X operand: 0 = Acc, 1 = PC
//  y_sel      out  1  ALU Y operand: 0 = memory read data, 1 = address mux output
//  alu_fs     out  2  00 pass Y, 01 X+Y, 10 Y+1, 11 X-Y
//  pc_en      out  1  load PC from ALU result
//  ir_en      out  1  load IR from memory read data
//  acc_en     out  1  load Acc from ALU result
//  mem_rd     out  1  memory read strobe
//  mem_wr     out  1  memory write strobe (data = Acc)
//  halted     out  1  registered, 1 while in HALT
// BEHAVIOUR
//  Reset: rst_n low -> state START immediately; all outputs 0 while in START.
//  States: START -> FETCH (unconditional, one cycle); FETCH -> EXEC; EXEC -> FETCH or HALT;
//   HALT -> HALT until rst_n low. Encoding is free; no other reachable states.
//  Outputs are combinational from state and opcode; pc_en/ir_en/acc_en are also gated by
//   mem_ready (Mealy) in any cycle where mem_rd or mem_wr is 1.
//  FETCH: addr_sel=0, y_sel=1, alu_fs=10, mem_rd=1; when mem_ready=1: ir_en=1, pc_en=1,
//   next EXEC; else hold FETCH, enables 0, strobes held.
//  EXEC by opcode (addr_sel=1 in every EXEC cycle):
//   0 LDA: mem_rd, y_sel=0, alu_fs=00, acc_en on ready
//   1 STA: mem_wr; no enables; complete on ready
//   2 ADD: mem_rd, x_sel=0, y_sel=0, alu_fs=01, acc_en on ready
//   3 SUB: as ADD with alu_fs=11
//   4 JMP: y_sel=1, alu_fs=00, pc_en=1; no memory access, ignores mem_ready
//   5 JGE: as JMP when flag_n=0, else all enables 0
//   6 JNE: as JMP when flag_z=0, else all enables 0
//   7 STP: no strobes/enables; next HALT
//   8-F: NOP, no strobes/enables; next FETCH
//  EXEC with memory access holds until mem_ready=1, then -> FETCH; non-memory EXEC is 1 cycle.
//  Latency (mem_ready tied 1): LDA/STA/ADD/SUB/JMP/NOP = 2 cycles each; halted rises on
//   the edge that leaves EXEC for STP.
//  Flags sampled in the EXEC cycle only; changes on flag_n/flag_z elsewhere are ignored.
//  opcode must be stable during EXEC (IR only loads in FETCH).
//  HALT: all strobes and enables 0, halted=1; opcode/mem_ready ignored.
//  Reset mid-access (any state, mem_rd/mem_wr asserted): strobes drop asynchronously,
//   state START, halted=0; no enable is issued for the aborted access.
//  Unused alu_fs/x_sel/y_sel values when don't-care are driven 0 (no X on outputs).
// TESTING
//  1 Reset: rst_n=0 mid-FETCH -> all outputs 0 same cycle; release -> START 1 cycle, then
//    FETCH with addr_sel=0, mem_rd=1, alu_fs=10.
//  2 mem_ready=1, opcode=0 (LDA) -> FETCH ir_en=pc_en=1, next EXEC addr_sel=1, mem_rd=1,
//    acc_en=1, back to FETCH after exactly 2 cycles.
//  3 FETCH with mem_ready=0 for 3 cycles then 1 -> mem_rd high 4 cycles, ir_en/pc_en only
//    on 4th; STA with mem_ready low 2 cycles -> mem_wr held 3 cycles, no enables.
//  4 opcode=5, flag_n=1 -> EXEC pc_en=0; flag_n=0 -> pc_en=1, y_sel=1, alu_fs=00.
//    opcode=6 with flag_z=1 -> pc_en=0; flag_z=0 -> pc_en=1.
//  5 opcode=7 -> halted=1 after EXEC; 10 further cycles with mem_ready toggling ->
//    all strobes/enables 0; rst_n pulse -> halted=0, START.
//  6 opcode=4'hA -> 2-cycle NOP, no strobes/enables in EXEC; random opcodes over 1000
//    instructions -> never mem_rd&mem_wr together, never ir_en outside FETCH.

Source files
------------

// File: rtl/mu0_control_if.sv
// Control-side bundle for the MU0 controller: instruction/flag/ready inputs plus
// the datapath selects, register enables and memory strobes it drives.
interface mu0_control_if;
    logic [3:0] opcode;
    logic       flag_n;
    logic       flag_z;
    logic       mem_ready;
    logic       addr_sel;
    logic       x_sel;
    logic       y_sel;
    logic [1:0] alu_fs;
    logic       pc_en;
    logic       ir_en;
    logic       acc_en;
    logic       mem_rd;
    logic       mem_wr;
    logic       halted;

    modport master (
        input  opcode, flag_n, flag_z, mem_ready,
        output addr_sel, x_sel, y_sel, alu_fs,
        output pc_en, ir_en, acc_en, mem_rd, mem_wr, halted
    );

    modport slave (
        output opcode, flag_n, flag_z, mem_ready,
        input  addr_sel, x_sel, y_sel, alu_fs,
        input  pc_en, ir_en, acc_en, mem_rd, mem_wr, halted
    );
endinterface

// File: rtl/mu0_control.sv
// MU0 fetch/execute sequencer: decodes the opcode into datapath selects and
// enables, stalls on the memory ready handshake and parks in HALT after STP.
module mu0_control (
    input  logic          clk,
    input  logic          rst_n,
    mu0_control_if.master bus
);
    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_INC  = 2'b10;
    localparam logic [1:0] ALU_SUB  = 2'b11;

    state_t     state_reg;
    state_t     state_next;
    logic       halted_reg;

    logic       addr_sel;
    logic       x_sel;
    logic       y_sel;
    logic [1:0] alu_fs;
    logic       pc_en;
    logic       ir_en;
    logic       acc_en;
    logic       mem_rd;
    logic       mem_wr;
    logic       take_jump;

    always_comb begin
        state_next = state_reg;
        addr_sel   = 1'b0;
        x_sel      = 1'b0;
        y_sel      = 1'b0;
        alu_fs     = ALU_PASS;
        pc_en      = 1'b0;
        ir_en      = 1'b0;
        acc_en     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        take_jump  = 1'b0;

        case (state_reg)
            START: state_next = FETCH;

            FETCH: begin
                // PC feeds the ALU via the address mux and is incremented while IR loads.
                y_sel  = 1'b1;
                alu_fs = ALU_INC;
                mem_rd = 1'b1;
                if (bus.mem_ready) begin
                    ir_en      = 1'b1;
                    pc_en      = 1'b1;
                    state_next = EXEC;
                end
            end

            EXEC: begin
                addr_sel   = 1'b1;
                state_next = FETCH;
                case (bus.opcode)
                    OP_LDA: begin
                        mem_rd = 1'b1;
                        acc_en = bus.mem_ready;
                    end
                    OP_STA: mem_wr = 1'b1;
                    OP_ADD: begin
                        mem_rd = 1'b1;
                        alu_fs = ALU_ADD;
                        acc_en = bus.mem_ready;
                    end
                    OP_SUB: begin
                        mem_rd = 1'b1;
                        alu_fs = ALU_SUB;
                        acc_en = bus.mem_ready;
                    end
                    OP_JMP: take_jump = 1'b1;
                    OP_JGE: take_jump = ~bus.flag_n;
                    OP_JNE: take_jump = ~bus.flag_z;
                    OP_STP: state_next = HALT;
                    default: ;
                endcase
                // Jump target is IR[11:0] routed through the address mux as Y.
                if (take_jump) begin
                    y_sel = 1'b1;
                    pc_en = 1'b1;
                end
                if ((mem_rd || mem_wr) && !bus.mem_ready) begin
                    state_next = EXEC;
                end
            end

            HALT: state_next = HALT;

            default: state_next = START;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= START;
            halted_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            halted_reg <= (state_next == HALT);
        end
    end

    assign bus.addr_sel = addr_sel;
    assign bus.x_sel    = x_sel;
    assign bus.y_sel    = y_sel;
    assign bus.alu_fs   = alu_fs;
    assign bus.pc_en    = pc_en;
    assign bus.ir_en    = ir_en;
    assign bus.acc_en   = acc_en;
    assign bus.mem_rd   = mem_rd;
    assign bus.mem_wr   = mem_wr;
    assign bus.halted   = halted_reg;

endmodule
